// File: rtl/mcx_pkg.sv
// Shared MCX definitions: instruction word geometry, field offsets and field types.
package mcx_pkg;

  localparam int INST_W   = 4;
  localparam int ARG_W    = 11;
  localparam int WORD_W   = INST_W + 3 * ARG_W;
  localparam int INST_LSB = 3 * ARG_W;
  localparam int ARG1_LSB = 2 * ARG_W;
  localparam int ARG2_LSB = ARG_W;
  localparam int ARG3_LSB = 0;

  typedef logic signed [INST_W-1:0] opcode_t;
  typedef logic signed [ARG_W-1:0]  arg_t;

  typedef struct packed {
    opcode_t inst;
    arg_t    arg1;
    arg_t    arg2;
    arg_t    arg3;
  } mcx_word_t;

  function automatic mcx_word_t unpack_word(input logic [WORD_W-1:0] w);
    mcx_word_t r;
    r.inst = w[INST_LSB +: INST_W];
    r.arg1 = w[ARG1_LSB +: ARG_W];
    r.arg2 = w[ARG2_LSB +: ARG_W];
    r.arg3 = w[ARG3_LSB +: ARG_W];
    return r;
  endfunction

endpackage

// File: rtl/mcx_fetch_if.sv
// Fetch-unit bus: ROM read port, instruction handshake to MCX, and control-flow inputs.
interface mcx_fetch_if import mcx_pkg::*; #(
  parameter int ADDR_W = 8
) ();

  logic [ADDR_W-1:0] rom_addr;
  logic [WORD_W-1:0] rom_data;
  logic              out_valid;
  logic              out_ready;
  opcode_t           out_inst;
  arg_t              out_arg1;
  arg_t              out_arg2;
  arg_t              out_arg3;
  logic [ADDR_W-1:0] out_pc;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;

  modport master (
    output rom_addr, out_valid, out_inst, out_arg1, out_arg2, out_arg3, out_pc,
    input  rom_data, out_ready, redirect, redirect_pc, halt
  );

  modport slave (
    input  rom_addr, out_valid, out_inst, out_arg1, out_arg2, out_arg3, out_pc,
    output rom_data, out_ready, redirect, redirect_pc, halt
  );

endinterface

// File: rtl/mcx_fetch_fifo.sv
// Two-entry in-order buffer; head register is the output and keeps its value when emptied.
module mcx_fetch_fifo #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] tail;
  logic [1:0]        left;

  assign left  = count - {1'b0, pop};
  assign dout  = head;
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

  // Shift-register organisation: head is always the oldest entry, so no read pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      if (pop && full)
        head <= tail;
      if (push) begin
        if (left == 2'd0)
          head <= din;
        else
          tail <= din;
      end
      count <= left + {1'b0, push};
    end
  end

endmodule

// File: rtl/mcx_fetch.sv
// MCX instruction fetch: issues ROM reads, buffers returned words, presents them in order.
module mcx_fetch import mcx_pkg::*; #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  mcx_fetch_if.master  bus
);

  // Encodings kept from the legacy state constants.
  localparam logic [1:0] ST_RESET  = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  typedef enum logic [1:0] {
    RESET  = ST_RESET,
    RUN    = ST_RUN,
    HALTED = ST_HALTED
  } state_t;

  state_t                   state;
  logic [ADDR_W-1:0]        pc;
  logic [ADDR_W-1:0]        inflight_pc;
  logic                     inflight;
  logic                     issue;
  logic                     push;
  logic                     pop;
  logic                     room;
  logic [1:0]               count;
  logic                     full;
  logic                     empty;
  logic [2:0]               occupancy;
  logic [ADDR_W+WORD_W-1:0] fifo_out;
  mcx_word_t                head_word;

  assign pop       = !empty && bus.out_ready;
  assign push      = inflight && !bus.redirect;
  assign occupancy = {1'b0, count} + {2'b00, inflight};
  // A pop always frees a slot; otherwise buffered plus in-flight must leave one free.
  assign room      = pop || (!full && (occupancy < 3'd2));
  assign issue     = (state == RUN) && !bus.halt && !bus.redirect && room;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RESET;
    end else begin
      case (state)
        RESET:   state <= RUN;
        RUN:     if (bus.halt) state <= HALTED;
        HALTED:  if (!bus.halt) state <= RUN;
        default: state <= RESET;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else begin
      inflight <= issue;
      if (issue)
        inflight_pc <= pc;
      if (bus.redirect)
        pc <= bus.redirect_pc;
      else if (issue)
        pc <= pc + 1'b1;
    end
  end

  mcx_fetch_fifo #(
    .DATA_W (ADDR_W + WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .din   ({inflight_pc, bus.rom_data}),
    .dout  (fifo_out),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign head_word     = unpack_word(fifo_out[WORD_W-1:0]);
  assign bus.rom_addr  = pc;
  assign bus.out_valid = !empty;
  assign bus.out_pc    = fifo_out[ADDR_W+WORD_W-1 -: ADDR_W];
  assign bus.out_inst  = head_word.inst;
  assign bus.out_arg1  = head_word.arg1;
  assign bus.out_arg2  = head_word.arg2;
  assign bus.out_arg3  = head_word.arg3;

endmodule

// File: tb/tb_mcx_fetch.sv
// Directed bench for mcx_fetch: reset, streaming, stall, redirect, halt, pc wrap.
module tb_mcx_fetch;
  import mcx_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  mcx_fetch_if #(.ADDR_W(8)) bus0 ();
  mcx_fetch_if #(.ADDR_W(8)) bus1 ();

  mcx_fetch #(.ADDR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  mcx_fetch #(.ADDR_W(8), .RESET_PC(8'hFE)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  // ROM word k = {k[3:0], k, -k, 2k}
  function automatic logic [WORD_W-1:0] rom_word(input logic [7:0] a);
    logic [ARG_W-1:0] k;
    k = {3'b000, a};
    return {a[3:0], k, -k, k << 1};
  endfunction

  always @(posedge clk) begin
    bus0.rom_data <= rom_word(bus0.rom_addr);
    bus1.rom_data <= rom_word(bus1.rom_addr);
  end

  logic [7:0] wrap_log [4];
  logic [2:0] wrap_n = '0;

  always @(negedge clk) begin
    if (bus1.out_valid && bus1.out_ready && wrap_n < 3'd4) begin
      wrap_log[wrap_n[1:0]] <= bus1.out_pc;
      wrap_n                <= wrap_n + 3'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_entry(input string tag, input logic [7:0] pc);
    opcode_t ei;
    arg_t    e1, e2, e3;
    ei = opcode_t'(pc[3:0]);
    e1 = arg_t'({3'b000, pc});
    e2 = -e1;
    e3 = e1 + e1;
    chk({tag, ".valid"}, 32'(bus0.out_valid), 32'd1);
    chk({tag, ".pc"},    32'(bus0.out_pc),    32'(pc));
    chk({tag, ".inst"},  32'(bus0.out_inst),  32'(ei));
    chk({tag, ".arg1"},  32'(bus0.out_arg1),  32'(e1));
    chk({tag, ".arg2"},  32'(bus0.out_arg2),  32'(e2));
    chk({tag, ".arg3"},  32'(bus0.out_arg3),  32'(e3));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic [7:0] addr);
    chk({tag, ".valid"}, 32'(bus0.out_valid), 32'd0);
    chk({tag, ".addr"},  32'(bus0.rom_addr),  32'(addr));
  endtask

  initial begin
    rst              = 1'b0;
    bus0.out_ready   = 1'b0;
    bus0.redirect    = 1'b0;
    bus0.redirect_pc = '0;
    bus0.halt        = 1'b0;
    bus1.out_ready   = 1'b1;
    bus1.redirect    = 1'b0;
    bus1.redirect_pc = '0;
    bus1.halt        = 1'b0;
    repeat (3) step();

    chk_idle("rst", 8'h00);
    chk("rst.out_pc", 32'(bus0.out_pc),   32'd0);
    chk("rst.inst",   32'(bus0.out_inst), 32'd0);
    chk("rst.arg1",   32'(bus0.out_arg1), 32'd0);
    chk("rst.arg3",   32'(bus0.out_arg3), 32'd0);
    chk("rst.wrap_addr",  32'(bus1.rom_addr),  32'h0FE);
    chk("rst.wrap_valid", 32'(bus1.out_valid), 32'd0);

    // release reset with out_ready low: first valid, then 5 stalled cycles
    rst = 1'b1;
    step(); chk_idle("rel.c0", 8'h00);
    step(); chk_idle("rel.c1", 8'h01);
    step(); chk_entry("rel.c2", 8'h00);
    chk("rel.c2.addr", 32'(bus0.rom_addr), 32'h02);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_entry("stall", 8'h00);
      chk("stall.addr", 32'(bus0.rom_addr), 32'h02);
    end

    bus0.out_ready = 1'b1;
    step(); chk_entry("drain1", 8'h01);
    step(); chk_entry("drain2", 8'h02);
    step(); chk_entry("drain3", 8'h03);
    chk("pre_redir.addr", 32'(bus0.rom_addr), 32'h05);

    // redirect while pc=0x05; entry 0x03 transfers, 0x04 in flight is dropped
    bus0.redirect    = 1'b1;
    bus0.redirect_pc = 8'h40;
    step();
    bus0.redirect = 1'b0;
    chk_idle("redir.c0", 8'h40);
    step(); chk_idle("redir.c1", 8'h41);
    step(); chk_entry("redir.40", 8'h40);
    step(); chk_entry("redir.41", 8'h41);
    step(); chk_entry("redir.42", 8'h42);
    chk("redir.addr", 32'(bus0.rom_addr), 32'h44);

    // halt for 4 cycles
    bus0.halt = 1'b1;
    step(); chk_entry("halt.43", 8'h43);
    step(); chk_idle("halt.h2", 8'h44);
    step(); chk_idle("halt.h3", 8'h44);
    step(); chk_idle("halt.h4", 8'h44);
    bus0.halt = 1'b0;
    step(); chk_idle("unhalt.c0", 8'h44);
    step(); chk_idle("unhalt.c1", 8'h45);
    step(); chk_entry("unhalt.44", 8'h44);
    step(); chk_entry("unhalt.45", 8'h45);

    // fill the buffer, then pulse reset
    bus0.out_ready = 1'b0;
    step(); chk_entry("full.45", 8'h45);
    chk("full.addr", 32'(bus0.rom_addr), 32'h47);
    rst = 1'b0;
    step();
    chk_idle("rst2", 8'h00);
    chk("rst2.out_pc", 32'(bus0.out_pc), 32'd0);
    rst            = 1'b1;
    bus0.out_ready = 1'b1;
    step(); chk_idle("rst2.c0", 8'h00);
    step(); chk_idle("rst2.c1", 8'h01);
    step(); chk_entry("rst2.00", 8'h00);
    step(); chk_entry("rst2.01", 8'h01);

    // redirect and halt together, then redirect while halted
    bus0.redirect    = 1'b1;
    bus0.redirect_pc = 8'h80;
    bus0.halt        = 1'b1;
    step();
    bus0.redirect = 1'b0;
    chk_idle("rh.c0", 8'h80);
    step(); chk_idle("rh.c1", 8'h80);
    bus0.redirect    = 1'b1;
    bus0.redirect_pc = 8'h90;
    step();
    bus0.redirect = 1'b0;
    chk_idle("hredir.c0", 8'h90);
    bus0.halt = 1'b0;
    step(); chk_idle("hredir.c1", 8'h90);
    step(); chk_idle("hredir.c2", 8'h91);
    step(); chk_entry("hredir.90", 8'h90);
    step(); chk_entry("hredir.91", 8'h91);

    // pc wrap on the RESET_PC=0xFE instance
    chk("wrap.count", 32'(wrap_n), 32'd4);
    chk("wrap.0", 32'(wrap_log[0]), 32'h0FE);
    chk("wrap.1", 32'(wrap_log[1]), 32'h0FF);
    chk("wrap.2", 32'(wrap_log[2]), 32'h000);
    chk("wrap.3", 32'(wrap_log[3]), 32'h001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
